mem_arbiter: RTL and testbench

- Shares one 128-bit-line main memory between the instruction cache (read-only) and the data cache (read/write).
- Sits between ins_cache_memory / data_cache_memory and a single data_memory instance, replacing the separate ins_memory.
- Registered grant FSM, busy-wait handshake on every side, and per-requester read-data hold registers.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one line memory between I-cache (read-only) and D-cache; grant 1 cycle after request, then one RELEASE cycle.
// Losers stall via combinational BUSY_WAIT; define MEM_ARB_RR_EN for round-robin ties instead of DATA_PRIORITY.
module mem_arbiter #(
    parameter int DATA_PRIORITY = 1,
    parameter int ADDR_W        = 28,
    parameter int LINE_W        = 128
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              INS_MEM_READ,
    input  logic [ADDR_W-1:0] INS_MEM_ADDRESS,
    output logic [LINE_W-1:0] INS_MEM_READ_DATA,
    output logic              INS_MEM_BUSY_WAIT,
    input  logic              DATA_MEM_READ,
    input  logic              DATA_MEM_WRITE,
    input  logic [ADDR_W-1:0] DATA_MEM_ADDRESS,
    input  logic [LINE_W-1:0] DATA_MEM_WRITE_DATA,
    output logic [LINE_W-1:0] DATA_MEM_READ_DATA,
    output logic              DATA_MEM_BUSY_WAIT,
    output logic              MAIN_MEM_READ,
    output logic              MAIN_MEM_WRITE,
    output logic [ADDR_W-1:0] MAIN_MEM_ADDRESS,
    output logic [LINE_W-1:0] MAIN_MEM_WRITE_DATA,
    input  logic [LINE_W-1:0] MAIN_MEM_READ_DATA,
    input  logic              MAIN_MEM_BUSY_WAIT
);

    typedef enum logic [1:0] {IDLE, GNT_INS, GNT_DATA, RELEASE} state_t;

    state_t            state_q, state_d;
    logic [LINE_W-1:0] hold_ins_q, hold_ins_d;
    logic [LINE_W-1:0] hold_data_q, hold_data_d;
    logic              ins_req, data_req, gnt_ins, gnt_data, tie_data;

    assign ins_req  = INS_MEM_READ;
    assign data_req = DATA_MEM_READ | DATA_MEM_WRITE;
    assign gnt_ins  = (state_q == GNT_INS);
    assign gnt_data = (state_q == GNT_DATA);

`ifdef MEM_ARB_RR_EN
    // last_grant: 0 = instruction cache served last, 1 = data cache
    logic last_grant_q, last_grant_d;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) last_grant_q <= 1'b0;
        else        last_grant_q <= last_grant_d;
    end

    assign tie_data = ~last_grant_q;
`else
    assign tie_data = (DATA_PRIORITY != 0);
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            hold_ins_q  <= '0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_ins_q  <= hold_ins_d;
            hold_data_q <= hold_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_ins_d  = hold_ins_q;
        hold_data_d = hold_data_q;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE, RELEASE: begin
                if (ins_req && data_req) state_d = tie_data ? GNT_DATA : GNT_INS;
                else if (data_req)       state_d = GNT_DATA;
                else if (ins_req)        state_d = GNT_INS;
                else                     state_d = IDLE;
            end
            GNT_INS: begin
                // A dropped request abandons the transfer without latching
                if (!ins_req || !MAIN_MEM_BUSY_WAIT) begin
                    state_d = RELEASE;
                    if (ins_req) hold_ins_d = MAIN_MEM_READ_DATA;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = 1'b0;
`endif
                end
            end
            GNT_DATA: begin
                if (!data_req || !MAIN_MEM_BUSY_WAIT) begin
                    state_d = RELEASE;
                    if (DATA_MEM_READ) hold_data_d = MAIN_MEM_READ_DATA;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        MAIN_MEM_READ       = 1'b0;
        MAIN_MEM_WRITE      = 1'b0;
        MAIN_MEM_ADDRESS    = '0;
        MAIN_MEM_WRITE_DATA = '0;
        if (gnt_ins) begin
            MAIN_MEM_READ    = INS_MEM_READ;
            MAIN_MEM_ADDRESS = INS_MEM_ADDRESS;
        end else if (gnt_data) begin
            MAIN_MEM_READ       = DATA_MEM_READ;
            MAIN_MEM_WRITE      = DATA_MEM_WRITE;
            MAIN_MEM_ADDRESS    = DATA_MEM_ADDRESS;
            MAIN_MEM_WRITE_DATA = DATA_MEM_WRITE_DATA;
        end
    end

    assign INS_MEM_READ_DATA  = gnt_ins  ? MAIN_MEM_READ_DATA : hold_ins_q;
    assign DATA_MEM_READ_DATA = gnt_data ? MAIN_MEM_READ_DATA : hold_data_q;
    assign INS_MEM_BUSY_WAIT  = ins_req  & ~(gnt_ins  & ~MAIN_MEM_BUSY_WAIT);
    assign DATA_MEM_BUSY_WAIT = data_req & ~(gnt_data & ~MAIN_MEM_BUSY_WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle main memory model and per-requester read-line scoreboards.
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ins_rd;
    logic [27:0]  ins_addr;
    logic [127:0] ins_rdata;
    logic         ins_bw;
    logic         d_rd, d_wr;
    logic [27:0]  d_addr;
    logic [127:0] d_wdata, d_rdata;
    logic         d_bw;
    logic         mm_rd, mm_wr;
    logic [27:0]  mm_addr;
    logic [127:0] mm_wdata, mm_rdata;
    logic         mm_bw;

    logic [127:0] mem [32];
    int           mcnt;

    logic [127:0] sb_ins[$];
    logic [127:0] sb_data[$];
    int           order[$];
    int           last_served;
    int           n_checks = 0;
    int           n_errors = 0;

    localparam logic [127:0] LINE_A5 = {16{8'hA5}};
    localparam logic [127:0] LINE_05 = {16{8'h05}};
    localparam logic [127:0] LINE_WR = {8{16'h1234}};

    mem_arbiter dut (
        .CLK                 (clk),
        .RESET               (rst_n),
        .INS_MEM_READ        (ins_rd),
        .INS_MEM_ADDRESS     (ins_addr),
        .INS_MEM_READ_DATA   (ins_rdata),
        .INS_MEM_BUSY_WAIT   (ins_bw),
        .DATA_MEM_READ       (d_rd),
        .DATA_MEM_WRITE      (d_wr),
        .DATA_MEM_ADDRESS    (d_addr),
        .DATA_MEM_WRITE_DATA (d_wdata),
        .DATA_MEM_READ_DATA  (d_rdata),
        .DATA_MEM_BUSY_WAIT  (d_bw),
        .MAIN_MEM_READ       (mm_rd),
        .MAIN_MEM_WRITE      (mm_wr),
        .MAIN_MEM_ADDRESS    (mm_addr),
        .MAIN_MEM_WRITE_DATA (mm_wdata),
        .MAIN_MEM_READ_DATA  (mm_rdata),
        .MAIN_MEM_BUSY_WAIT  (mm_bw)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [127:0] init_line(input int i);
        if (i == 16) return LINE_A5;
        return {16{8'(i)}};
    endfunction

    // Main memory: busy from the first request cycle, completes in cycle LAT+1
    always_comb begin
        mm_rdata = mem[mm_addr[4:0]];
        mm_bw    = (mm_rd || mm_wr) && (mcnt < LAT);
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            mcnt <= 0;
            for (int i = 0; i < 32; i++) mem[i] <= init_line(i);
        end else if ((mm_rd || mm_wr) && mm_bw) begin
            mcnt <= mcnt + 1;
        end else begin
            mcnt <= 0;
            if (mm_wr) mem[mm_addr[4:0]] <= mm_wdata;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs active requests to completion, scoring read lines and dropping each request after its completion edge
    task automatic serve(input int budget);
        int cyc;
        bit di, dd;
        logic [127:0] exp;
        cyc = 0;
        while ((ins_rd || d_rd || d_wr) && cyc < budget) begin
            @(negedge clk);
            di = 0;
            dd = 0;
            if (ins_rd && !ins_bw) begin
                exp = (sb_ins.size() != 0) ? sb_ins.pop_front() : 'x;
                chk("ins_line", ins_rdata, exp);
                chk("data_stalled", 128'(d_bw), 128'(d_rd || d_wr));
                order.push_back(0);
                last_served = 0;
                di = 1;
            end
            if ((d_rd || d_wr) && !d_bw) begin
                if (d_rd) begin
                    exp = (sb_data.size() != 0) ? sb_data.pop_front() : 'x;
                    chk("data_line", d_rdata, exp);
                end
                chk("ins_stalled", 128'(ins_bw), 128'(ins_rd));
                order.push_back(1);
                last_served = 1;
                dd = 1;
            end
            tick();
            if (di) ins_rd = 1'b0;
            if (dd) begin
                d_rd = 1'b0;
                d_wr = 1'b0;
            end
            cyc++;
        end
        chk("serve_timeout", 128'({ins_rd, d_rd, d_wr}), 128'(0));
        ins_rd = 1'b0;
        d_rd   = 1'b0;
        d_wr   = 1'b0;
    endtask

    initial begin
        int exp_w;
        rst_n = 1'b0; ins_rd = 1'b1; d_rd = 1'b1; d_wr = 1'b0;
        ins_addr = 28'h10; d_addr = 28'h5; d_wdata = '0;
        last_served = 0;

        // Reset with both requests high
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mm_rd", 128'(mm_rd), 128'(0));
        chk("rst_mm_wr", 128'(mm_wr), 128'(0));
        chk("rst_mm_addr", 128'(mm_addr), 128'(0));
        chk("rst_mm_wdata", mm_wdata, 128'(0));
        chk("rst_ins_rdata", ins_rdata, 128'(0));
        chk("rst_d_rdata", d_rdata, 128'(0));
        chk("rst_ins_bw", 128'(ins_bw), 128'(1));
        chk("rst_d_bw", 128'(d_bw), 128'(1));
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_gnt_rd", 128'(mm_rd), 128'(1));
        chk("first_gnt_addr", 128'(mm_addr), 128'(28'h5));
        sb_data.push_back(LINE_05);
        sb_ins.push_back(LINE_A5);
        order.delete();
        serve(40);
        chk("prio_first", 128'(order.size() > 0 ? order[0] : -1), 128'(1));
        chk("prio_second", 128'(order.size() > 1 ? order[1] : -1), 128'(0));
        tick();

        // Lone instruction read, exact cycle timing
        ins_rd = 1'b1;
        sb_ins.push_back(LINE_A5);
        @(negedge clk);
        chk("ins_c0_bw", 128'(ins_bw), 128'(1));
        chk("ins_c0_rd", 128'(mm_rd), 128'(0));
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("ins_mm_rd", 128'(mm_rd), 128'(1));
            chk("ins_bw_cyc", 128'(ins_bw), 128'(c != 5));
            if (c == 5) chk("ins_pass", ins_rdata, sb_ins.pop_front());
        end
        tick();
        ins_rd = 1'b0;
        @(negedge clk);
        chk("ins_rel_rd", 128'(mm_rd), 128'(0));
        chk("ins_hold", ins_rdata, LINE_A5);
        tick();

        // Write-back then immediate read of the same line
        d_wr = 1'b1; d_addr = 28'h3; d_wdata = LINE_WR;
        serve(20);
        d_rd = 1'b1;
        @(negedge clk);
        chk("rel_d_bw", 128'(d_bw), 128'(1));
        chk("rel_mm_rd", 128'(mm_rd), 128'(0));
        chk("rel_mm_wr", 128'(mm_wr), 128'(0));
        chk("wr_hold_kept", d_rdata, LINE_05);
        tick();
        @(negedge clk);
        chk("rd_gnt", 128'(mm_rd), 128'(1));
        chk("rd_addr", 128'(mm_addr), 128'(28'h3));
        sb_data.push_back(LINE_WR);
        serve(20);
        @(negedge clk);
        chk("rd_hold", d_rdata, LINE_WR);
        tick();

        // Three fresh ties
        for (int k = 0; k < 3; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_w = (last_served == 0) ? 1 : 0;
`else
            exp_w = 1;
`endif
            ins_rd = 1'b1; d_rd = 1'b1; ins_addr = 28'h10; d_addr = 28'h3;
            sb_ins.push_back(LINE_A5);
            sb_data.push_back(LINE_WR);
            order.delete();
            serve(40);
            chk("tie_winner", 128'(order.size() > 0 ? order[0] : -1), 128'(exp_w));
            tick();
        end

        // Data request abandoned mid-grant with an instruction read pending
        d_rd = 1'b1; d_addr = 28'h3;
        tick();
        ins_rd = 1'b1; ins_addr = 28'h10;
        @(negedge clk);
        chk("ab_gnt", 128'(mm_rd), 128'(1));
        chk("ab_ins_bw", 128'(ins_bw), 128'(1));
        tick();
        d_rd = 1'b0;
        last_served = 1;
        @(negedge clk);
        chk("ab_d_bw", 128'(d_bw), 128'(0));
        tick();
        @(negedge clk);
        chk("ab_rel_rd", 128'(mm_rd), 128'(0));
        chk("ab_rel_ins_bw", 128'(ins_bw), 128'(1));
        chk("ab_hold", d_rdata, LINE_WR);
        tick();
        @(negedge clk);
        chk("ab_ins_gnt", 128'(mm_rd), 128'(1));
        chk("ab_ins_addr", 128'(mm_addr), 128'(28'h10));
        sb_ins.push_back(LINE_A5);
        serve(20);
        tick();

        // Asynchronous reset while the instruction read waits on memory
        ins_rd = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("mr_gnt", 128'(mm_rd), 128'(1));
        rst_n = 1'b0;
        last_served = 0;
        #1;
        chk("mr_mm_rd", 128'(mm_rd), 128'(0));
        chk("mr_ins_rdata", ins_rdata, 128'(0));
        chk("mr_d_rdata", d_rdata, 128'(0));
        chk("mr_ins_bw", 128'(ins_bw), 128'(1));
        ins_rd = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("post_rst_idle", 128'(mm_rd), 128'(0));
        chk("sb_empty", 128'(sb_ins.size() + sb_data.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
